// File: rtl/port_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter_if
// Bundles the N sync/notify input ports and the single sync/notify output port
// of the round-robin arbiter.
//
// Signals:
//   in_data    N*DW  input payloads, port i at [i*DW +: DW]
//   in_sync    N     producer i has valid data
//   in_notify  N     arbiter reads port i this cycle (one-hot or zero)
//   out_data   DW    forwarded payload
//   out_src    SW    source index of out_data
//   out_sync   1     consumer ready
//   out_notify 1     out_data/out_src valid
//
// Modports:
//   master : producer/consumer side (drives in_data, in_sync, out_sync)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface port_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 32
);
  localparam int SW = $clog2(N);

  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_sync;
  logic [N-1:0]    in_notify;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_sync;
  logic            out_notify;

  modport master (
    output in_data,
    output in_sync,
    output out_sync,
    input  in_notify,
    input  out_data,
    input  out_src,
    input  out_notify
  );

  modport slave (
    input  in_data,
    input  in_sync,
    input  out_sync,
    output in_notify,
    output out_data,
    output out_src,
    output out_notify
  );
endinterface

// File: rtl/port_rr_arbiter.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter
// Shares one blocking output port among N blocking sync/notify input ports.
// Each accepted message is forwarded unchanged and tagged with its source
// index. One transfer is in flight at a time (IDLE -> ACCEPT -> SEND).
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  port_rr_arbiter_if.slave (see interface for signal list)
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module port_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  port_rr_arbiter_if.slave      bus
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCEPT = 2'b01,
    SEND   = 2'b10
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_win;
  logic [SW-1:0] r_src;
  logic [DW-1:0] r_data;
  logic [N-1:0]  r_in_notify;
  logic          r_out_notify;

  logic [DW-1:0] w_words [N];
  logic [SW-1:0] w_cand  [N];
  logic [SW-1:0] w_pick;
  logic          w_any;
  logic [SW:0]   w_win_sum;
  logic [SW-1:0] w_win_next;

  // Split the flat payload bus into per-port words and build the scan order
  // ptr, ptr+1, ... (mod N). Candidate gi is the port examined at scan step gi.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_port
      logic [SW:0] w_sum;
      assign w_words[gi] = bus.in_data[gi*DW +: DW];
      assign w_sum       = {1'b0, r_ptr} + (SW+1)'(gi);
      assign w_cand[gi]  = (w_sum >= (SW+1)'(N)) ? SW'(w_sum - (SW+1)'(N))
                                                 : w_sum[SW-1:0];
    end
  endgenerate

  // Walk the scan order backwards so the earliest requesting candidate
  // (nearest to ptr) is the last assignment and therefore wins.
  always_comb begin
    w_any  = |bus.in_sync;
    w_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.in_sync[w_cand[k]]) begin
        w_pick = w_cand[k];
      end
    end
  end

  // Pointer after a delivered message: one past the winner, wrapping at N.
  assign w_win_sum  = {1'b0, r_win} + (SW+1)'(1);
  assign w_win_next = (w_win_sum >= (SW+1)'(N)) ? '0 : w_win_sum[SW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_win        <= '0;
      r_src        <= '0;
      r_data       <= '0;
      r_in_notify  <= '0;
      r_out_notify <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_notify  <= '0;
          r_out_notify <= 1'b0;
          if (w_any) begin
            r_win       <= w_pick;
            r_in_notify <= {{(N-1){1'b0}}, 1'b1} << w_pick;
            r_state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          r_in_notify <= '0;
          if (bus.in_sync[r_win]) begin
            r_data       <= w_words[r_win];
            r_src        <= r_win;
            r_out_notify <= 1'b1;
            r_state      <= SEND;
          end else begin
            // Producer withdrew: no transfer, pointer stays where it was.
            r_state <= IDLE;
          end
        end
        SEND: begin
          if (bus.out_sync) begin
            r_out_notify <= 1'b0;
            r_ptr        <= w_win_next;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_in_notify  <= '0;
          r_out_notify <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_notify  = r_in_notify;
  assign bus.out_data   = r_data;
  assign bus.out_src    = r_src;
  assign bus.out_notify = r_out_notify;

endmodule
